// File: rtl/seq_mult_unit.sv
// -----------------------------------------------------------------------------
// seq_mult_unit
//
// Iterative shift-add multiplier for the ALU multiply path. One multiplier bit
// is retired per clock, followed by a single sign-correction cycle. The
// 2*WIDTH-bit product is registered in dataOut and held until the next
// operation completes, so the HI/LO write path always sees a stable value.
//
// Operation modes (selected by Signal when start is accepted):
//   6'd25  MULTU  unsigned x unsigned
//   6'd24  MULT   signed (two's complement) x signed
// Any other Signal value makes start a no-op.
//
// Optional build macro:
//   MULT_EARLY_TERM_EN  when defined, the RUN phase ends as soon as the
//                       remaining multiplier bits are all zero (minimum one
//                       RUN cycle). Results and handshake are unchanged; only
//                       latency shrinks. When undefined, RUN always lasts
//                       exactly WIDTH cycles.
//
// Parameters:
//   WIDTH   operand width in bits, 4..64
//   CNT_W   iteration counter width, derived from WIDTH (local)
//
// Ports:
//   clk      in   1        rising-edge clock
//   reset    in   1        synchronous, active-high reset
//   start    in   1        request pulse, sampled only in IDLE
//   Signal   in   6        op code (24 = MULT, 25 = MULTU)
//   dataA    in   WIDTH    multiplicand, captured on the accepting edge
//   dataB    in   WIDTH    multiplier, captured on the accepting edge
//   busy     out  1        high whenever the unit is not IDLE
//   done     out  1        one-cycle completion pulse
//   dataOut  out  2*WIDTH  registered product
//
// States:
//   state  | meaning
//   IDLE   | waiting for an accepted start; dataOut holds last result
//   RUN    | one shift-add iteration per clock
//   FIX    | apply sign correction, write dataOut, pulse done
// -----------------------------------------------------------------------------
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           Signal,
    input  logic [WIDTH-1:0]     dataA,
    input  logic [WIDTH-1:0]     dataB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   dataOut
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0]       OP_MULT  = 6'd24;
    localparam logic [5:0]       OP_MULTU = 6'd25;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q,  state_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic                 sign_q,   sign_d;
    logic [2*WIDTH-1:0]   dout_q,   dout_d;
    logic                 done_q,   done_d;

    // Operand decode for the accepting edge.
    logic                 op_valid;
    logic                 op_signed;
    logic                 a_neg;
    logic                 b_neg;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;

    assign op_signed = (Signal == OP_MULT);
    assign op_valid  = (Signal == OP_MULT) || (Signal == OP_MULTU);
    assign a_neg     = op_signed & dataA[WIDTH-1];
    assign b_neg     = op_signed & dataB[WIDTH-1];

    // Negating the most negative value wraps back to 2^(WIDTH-1), which is
    // exactly its magnitude when read as an unsigned WIDTH-bit number.
    assign a_mag     = a_neg ? (~dataA + WIDTH'(1)) : dataA;
    assign b_mag     = b_neg ? (~dataB + WIDTH'(1)) : dataB;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        dout_d   = dout_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && op_valid) begin
                    state_d  = S_RUN;
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    sign_d   = a_neg ^ b_neg;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end

            S_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
`ifdef MULT_EARLY_TERM_EN
                // No set bits left: remaining iterations would add nothing.
                if (mplier_d == '0) begin
                    state_d = S_FIX;
                end
`endif
            end

            S_FIX: begin
                dout_d  = sign_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            dout_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            dout_q   <= dout_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign dataOut = dout_q;

endmodule
